// File: rtl/spi_pkg.sv
// Shared constants, FSM encoding and counter helper for the SPI slave.
package spi_pkg;

  localparam int SPI_MAX_BITS    = 32;
  localparam int SPI_CMD_BITS_3W = 8;
  localparam int SPI_CNT_W       = 6;

  localparam logic [SPI_CNT_W-1:0] SPI_CNT_MAX = SPI_CNT_W'(SPI_MAX_BITS);
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_CMD = SPI_CNT_W'(SPI_CMD_BITS_3W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } spi_state_t;

  // Bit counter sticks at SPI_CNT_MAX; overflow is tracked separately.
  function automatic logic [SPI_CNT_W-1:0] cnt_sat_inc(input logic [SPI_CNT_W-1:0] c);
    return (c == SPI_CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Local-side port bundle of spi_slave: transmit word in, received frame out, FSM state for debug.
interface spi_slave_if;
  import spi_pkg::*;

  logic [SPI_MAX_BITS-1:0] tx_data;
  logic [SPI_MAX_BITS-1:0] rx_data;
  logic [SPI_CNT_W-1:0]    rx_count;
  logic                    rx_valid;
  logic                    rx_overrun;
  logic                    busy;
  spi_state_t              state;

  // rx_valid is a single-cycle strobe with no back-pressure: local logic must
  // take rx_data/rx_count/rx_overrun in that cycle or later, they hold until the next strobe.
  modport slave (
    input  tx_data,
    output rx_data, rx_count, rx_valid, rx_overrun, busy, state
  );

  modport master (
    output tx_data,
    input  rx_data, rx_count, rx_valid, rx_overrun, busy, state
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_dly  <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/spi_slave.sv
// Clock-oversampled SPI slave (SCK idles high, MSB first, sample on SCK rise).
// Define SPI_SLAVE_3WIRE_EN to make spi_mosi bidirectional and add the spi3w input.
module spi_slave
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic clk_in,
  input  logic nrst,
  input  logic spi_csn,
  input  logic spi_sck,
`ifdef SPI_SLAVE_3WIRE_EN
  inout  wire  spi_mosi,
  input  logic spi3w,
`else
  input  logic spi_mosi,
`endif
  output logic spi_miso,
  spi_slave_if.slave loc
);

  logic w_csn_level, w_csn_rise, w_csn_fall;
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_mosi,      w_mosi_rise, w_mosi_fall;
  logic w_3w;

  // CSN chain resets low so a frame already in progress at reset release is not seen as a start.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_csn (
    .i_clk(clk_in), .i_rst_n(nrst), .i_pin(spi_csn),
    .o_level(w_csn_level), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
    .i_clk(clk_in), .i_rst_n(nrst), .i_pin(spi_sck),
    .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(clk_in), .i_rst_n(nrst), .i_pin(spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  spi_state_t              r_state;
  logic [SPI_MAX_BITS-1:0] r_tx_shift;
  logic [SPI_MAX_BITS-1:0] r_rx_shift;
  logic [SPI_CNT_W-1:0]    r_cnt;
  logic                    r_ovr;
  logic [SPI_MAX_BITS-1:0] r_rx_data;
  logic [SPI_CNT_W-1:0]    r_rx_count;
  logic                    r_rx_valid;
  logic                    r_rx_overrun;
  logic                    r_busy;
  logic                    r_drive;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_cnt        <= '0;
      r_ovr        <= 1'b0;
      r_rx_data    <= '0;
      r_rx_count   <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_busy       <= 1'b0;
      r_drive      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_csn_fall) begin
            r_tx_shift <= loc.tx_data;
            r_rx_shift <= '0;
            r_cnt      <= '0;
            r_ovr      <= 1'b0;
            r_busy     <= 1'b1;
            r_drive    <= 1'b0;
            r_state    <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_sck_rise) begin
            r_rx_shift <= {r_rx_shift[SPI_MAX_BITS-2:0], w_mosi};
            r_cnt      <= cnt_sat_inc(r_cnt);
            if (r_cnt == SPI_CNT_MAX) r_ovr <= 1'b1;
            // In 3-wire mode the command phase leaves tx_data[31] parked for bit 9.
            if (!(w_3w && (r_cnt < SPI_CNT_CMD)))
              r_tx_shift <= {r_tx_shift[SPI_MAX_BITS-2:0], 1'b0};
          end
          if (w_sck_fall && w_3w && (r_cnt >= SPI_CNT_CMD)) r_drive <= 1'b1;
          if (w_csn_rise) begin
            r_drive <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (r_cnt != '0) begin
            r_rx_data    <= r_rx_shift;
            r_rx_count   <= r_cnt;
            r_rx_overrun <= r_ovr;
            r_rx_valid   <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spi_miso = ((r_state == ST_ACTIVE) && !w_3w) ? r_tx_shift[SPI_MAX_BITS-1] : IDLE_MISO;

`ifdef SPI_SLAVE_3WIRE_EN
  assign w_3w     = spi3w;
  assign spi_mosi = r_drive ? r_tx_shift[SPI_MAX_BITS-1] : 1'bz;
  logic w_unused;
  assign w_unused = &{1'b0, w_csn_level, w_sck_level, w_mosi_rise, w_mosi_fall};
`else
  assign w_3w = 1'b0;
  logic w_unused;
  assign w_unused = &{1'b0, w_csn_level, w_sck_level, w_mosi_rise, w_mosi_fall, r_drive};
`endif

  assign loc.rx_data    = r_rx_data;
  assign loc.rx_count   = r_rx_count;
  assign loc.rx_valid   = r_rx_valid;
  assign loc.rx_overrun = r_rx_overrun;
  assign loc.busy       = r_busy;
  assign loc.state      = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master, received-frame scoreboard, single summary line.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int HALF = 8;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic nrst;
  always #5 clk_in = ~clk_in;

  logic r_csn, r_sck, r_mosi;
  wire  w_mosi;
  logic spi_miso;
  assign w_mosi = r_mosi;

  spi_slave_if u_if ();

`ifdef SPI_SLAVE_3WIRE_EN
  logic r_spi3w = 1'b0;
  spi_slave dut (
    .clk_in(clk_in), .nrst(nrst), .spi_csn(r_csn), .spi_sck(r_sck),
    .spi_mosi(w_mosi), .spi3w(r_spi3w), .spi_miso(spi_miso), .loc(u_if)
  );
`else
  spi_slave dut (
    .clk_in(clk_in), .nrst(nrst), .spi_csn(r_csn), .spi_sck(r_sck),
    .spi_mosi(w_mosi), .spi_miso(spi_miso), .loc(u_if)
  );
`endif

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [38:0] exp_q[$];
  logic [38:0] mon_e;

  task automatic expect_rx(input logic ovr, input logic [5:0] cnt, input logic [31:0] data);
    exp_q.push_back({ovr, cnt, data});
  endtask

  always @(negedge clk_in) begin
    if (nrst && u_if.rx_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rx_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data",    u_if.rx_data,    mon_e[31:0]);
        check("rx_count",   u_if.rx_count,   mon_e[37:32]);
        check("rx_overrun", u_if.rx_overrun, mon_e[38]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic frame_start(input logic [31:0] tx);
    u_if.tx_data = tx;
    r_csn = 1'b0;
    tick(HALF);
  endtask

  task automatic sck_bit(input logic b, output logic m);
    r_sck  = 1'b0;
    r_mosi = b;
    tick(HALF);
    m      = spi_miso;
    r_sck  = 1'b1;
    tick(HALF);
  endtask

  task automatic frame_end();
    r_csn = 1'b1;
    tick(HALF);
  endtask

  task automatic xfer(input int n, input logic [31:0] mosi_w, input logic fill,
                      input logic [31:0] tx, output logic [31:0] miso_w);
    logic m;
    miso_w = '0;
    frame_start(tx);
    for (int i = 0; i < n; i++) begin
      sck_bit((i < 32) ? mosi_w[31-i] : fill, m);
      miso_w = {miso_w[30:0], m};
    end
    frame_end();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      tick(1);
      t++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"},     spi_miso,        1'b1);
    check({tag, "_rx_data"},  u_if.rx_data,    32'h0);
    check({tag, "_rx_count"}, u_if.rx_count,   6'd0);
    check({tag, "_rx_valid"}, u_if.rx_valid,   1'b0);
    check({tag, "_overrun"},  u_if.rx_overrun, 1'b0);
    check({tag, "_busy"},     u_if.busy,       1'b0);
    check({tag, "_state"},    u_if.state,      ST_IDLE);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] mw;
    logic        dummy;
    logic        seen;
    int          n;
    logic [31:0] mosi_r, tx_r;

    r_csn = 1'b1; r_sck = 1'b1; r_mosi = 1'b0;
    u_if.tx_data = '0;
    nrst = 1'b0;
    tick(4);
    check_reset_vals("reset");
    nrst = 1'b1;
    tick(4);

    // 8-bit frame
    expect_rx(1'b0, 6'd8, 32'h0000_00A5);
    xfer(8, 32'hA500_0000, 1'b0, 32'hC300_0000, mw);
    check("byte_miso", mw[7:0], 8'hC3);
    drain("byte");

    // full 32-bit frame
    expect_rx(1'b0, 6'd32, 32'hDEAD_BEEF);
    xfer(32, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, mw);
    check("word_miso", mw, 32'hDEAD_BEEF);
    drain("word");
    check("word_busy_after", u_if.busy, 1'b0);

    // 34 rises: count saturates, overrun set, last 32 bits kept
    expect_rx(1'b1, 6'd32, 32'hFFFF_FFFF);
    xfer(34, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, mw);
    check("ovr_miso", mw, 32'h48D1_59E0);
    drain("ovr");

    // CSN pulse without SCK: busy pulses, no strobe, outputs unchanged
    seen  = 1'b0;
    r_csn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (u_if.busy) seen = 1'b1;
    end
    r_csn = 1'b1;
    tick(20);
    check("empty_busy_pulse", seen, 1'b1);
    check("empty_busy_after", u_if.busy, 1'b0);
    check("empty_rx_data",    u_if.rx_data, 32'hFFFF_FFFF);
    check("empty_rx_count",   u_if.rx_count, 6'd32);
    check("empty_overrun",    u_if.rx_overrun, 1'b1);

    // reset after 5 bits, released with CSN still low
    frame_start(32'hFFFF_0000);
    for (int i = 0; i < 5; i++) sck_bit(1'b1, dummy);
    nrst = 1'b0;
    tick(1);
    check_reset_vals("midreset");
    tick(3);
    nrst = 1'b1;
    tick(10);
    for (int i = 0; i < 3; i++) sck_bit(1'b1, dummy);
    frame_end();
    tick(20);
    check("stale_frame_state", u_if.state, ST_IDLE);
    check("stale_frame_count", u_if.rx_count, 6'd0);

    expect_rx(1'b0, 6'd16, 32'h0000_1234);
    xfer(16, 32'h1234_0000, 1'b0, 32'h0, mw);
    drain("after_reset");

    // random lengths and data
    for (int k = 0; k < 4; k++) begin
      n      = $urandom_range(1, 32);
      mosi_r = $urandom;
      tx_r   = $urandom;
      expect_rx(1'b0, 6'(n), mosi_r >> (32 - n));
      xfer(n, mosi_r, 1'b0, tx_r, mw);
      check("rand_miso", mw, tx_r >> (32 - n));
      drain("rand");
    end

    tick(20);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
